// File: rtl/mac_pkg.sv
// Shared MAC-array definitions: default widths, drain FSM states and a small
// index helper used by the result drain.
package mac_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_SEND = 2'd1,
    DRAIN_FIN  = 2'd2
  } drain_state_e;

  // Row-major successor of a 2x2 element index; 3 wraps back to 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/mac_sat_shift.sv
// Arithmetic right shift of a signed accumulator followed by signed
// saturation into OUT_W bits; flags when clipping occurred.
module mac_sat_shift #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  localparam int HI_W = ACC_W - OUT_W + 1;

  logic signed [ACC_W-1:0] shifted_s;
  logic        [HI_W-1:0]  hi_s;

  assign shifted_s = acc >>> SHIFT;
  // The value fits when every bit from the output sign bit upward agrees.
  assign hi_s      = shifted_s[ACC_W-1:OUT_W-1];

  // Pass through in range, otherwise clip to the signed extreme of the sign.
  always_comb begin
    data = shifted_s[OUT_W-1:0];
    sat  = 1'b0;
    if ((hi_s == {HI_W{1'b0}}) || (hi_s == {HI_W{1'b1}})) begin
      data = shifted_s[OUT_W-1:0];
      sat  = 1'b0;
    end else if (shifted_s[ACC_W-1]) begin
      data = {1'b1, {(OUT_W-1){1'b0}}};
      sat  = 1'b1;
    end else begin
      data = {1'b0, {(OUT_W-1){1'b1}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_result_drain.sv
// Drain side of the 2x2 MAC array: snapshots the accumulators on start,
// streams four scaled results row-major over valid/ready, then pulses clear.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = DATA_W_DEF,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] acc_in [2][2],
  output logic                    busy,
  output logic signed [OUT_W-1:0] out_data,
  output logic        [1:0]       out_idx,
  output logic                    out_sat,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    clear_req,
  output logic                    done
);

  drain_state_e            state_q, state_d;
  logic        [1:0]       idx_q, idx_d;
  logic signed [ACC_W-1:0] snap_q [2][2];
  logic signed [ACC_W-1:0] snap_d [2][2];
  logic                    handshake_s;
  logic signed [ACC_W-1:0] sel_acc_s;
  logic signed [OUT_W-1:0] sat_data_s;
  logic                    sat_flag_s;

  assign handshake_s = (state_q == DRAIN_SEND) && out_ready;
  assign sel_acc_s   = snap_q[idx_q[1]][idx_q[0]];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DRAIN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DRAIN_IDLE: begin
        if (start) begin
          state_d = DRAIN_SEND;
        end else begin
          state_d = DRAIN_IDLE;
        end
      end
      DRAIN_SEND: begin
        if (handshake_s && (idx_q == 2'd3)) begin
          state_d = DRAIN_FIN;
        end else begin
          state_d = DRAIN_SEND;
        end
      end
      DRAIN_FIN: state_d = DRAIN_IDLE;
      default:   state_d = DRAIN_IDLE;
    endcase
  end

  // Snapshot capture and beat index advance; start is only heard in IDLE.
  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    case (state_q)
      DRAIN_IDLE: begin
        idx_d = 2'd0;
        if (start) begin
          snap_d = acc_in;
        end else begin
          snap_d = snap_q;
        end
      end
      DRAIN_SEND: begin
        if (handshake_s) begin
          idx_d = next_idx(idx_q);
        end else begin
          idx_d = idx_q;
        end
      end
      DRAIN_FIN: idx_d = 2'd0;
      default:   idx_d = 2'd0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= 2'd0;
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) begin
          snap_q[r][c] <= {ACC_W{1'b0}};
        end
      end
    end else begin
      idx_q  <= idx_d;
      snap_q <= snap_d;
    end
  end

  mac_sat_shift #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .acc  (sel_acc_s),
    .data (sat_data_s),
    .sat  (sat_flag_s)
  );

  // Outputs decode only the state, index and snapshot flops, so beats hold
  // steady under backpressure and read zero outside SEND.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = {OUT_W{1'b0}};
    out_idx   = 2'd0;
    out_sat   = 1'b0;
    out_last  = 1'b0;
    clear_req = 1'b0;
    done      = 1'b0;
    case (state_q)
      DRAIN_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = sat_data_s;
        out_idx   = idx_q;
        out_sat   = sat_flag_s;
        out_last  = (idx_q == 2'd3);
      end
      DRAIN_FIN: begin
        busy      = 1'b1;
        clear_req = 1'b1;
        done      = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Scoreboard bench for mac_result_drain: one instance with SHIFT=0 and one
// with SHIFT=4, directed drains with hand-computed expected beats.
module tb_mac_result_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, ready0, start4, ready4;
  logic signed [31:0] acc0 [2][2];
  logic signed [31:0] acc4 [2][2];

  logic               busy0, v0, sat0, last0, clr0, done0;
  logic signed [15:0] data0;
  logic [1:0]         idx0;
  logic               busy4, v4, sat4, last4, clr4, done4;
  logic signed [15:0] data4;
  logic [1:0]         idx4;

  mac_result_drain #(.ACC_W(32), .OUT_W(16), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .acc_in(acc0), .busy(busy0),
    .out_data(data0), .out_idx(idx0), .out_sat(sat0), .out_last(last0),
    .out_valid(v0), .out_ready(ready0), .clear_req(clr0), .done(done0)
  );

  mac_result_drain #(.ACC_W(32), .OUT_W(16), .SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .acc_in(acc4), .busy(busy4),
    .out_data(data4), .out_idx(idx4), .out_sat(sat4), .out_last(last4),
    .out_valid(v4), .out_ready(ready4), .clear_req(clr4), .done(done4)
  );

  typedef struct {
    int data;
    int idx;
    int sat;
    int last;
  } beat_t;

  beat_t q0[$];
  beat_t q4[$];
  int n_cmp = 0;
  int n_bad = 0;
  int hs0 = 0, hs4 = 0, clr_cnt0 = 0, clr_cnt4 = 0;
  int hs_b, clr_b;

  logic               stall0 = 1'b0;
  logic signed [15:0] prev_data0;
  logic [1:0]         prev_idx0;
  logic               prev_sat0, prev_last0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input int d, input int i, input int s, input int l);
    beat_t b;
    b.data = d; b.idx = i; b.sat = s; b.last = l;
    q0.push_back(b);
  endtask

  task automatic push4(input int d, input int i, input int s, input int l);
    beat_t b;
    b.data = d; b.idx = i; b.sat = s; b.last = l;
    q4.push_back(b);
  endtask

  task automatic set_acc0(input int a, input int b, input int c, input int d);
    acc0[0][0] = a; acc0[0][1] = b; acc0[1][0] = c; acc0[1][1] = d;
  endtask

  task automatic set_acc4(input int a, input int b, input int c, input int d);
    acc4[0][0] = a; acc4[0][1] = b; acc4[1][0] = c; acc4[1][1] = d;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  // Monitor for the SHIFT=0 instance: scoreboard pops, stall stability, clear pulses.
  always @(negedge clk) begin : mon0
    beat_t e;
    if (rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        chk("valid held during stall", int'(v0), 1);
        chk("stall data stable", int'(data0), int'(prev_data0));
        chk("stall idx stable", int'(idx0), int'(prev_idx0));
        chk("stall sat stable", int'(sat0), int'(prev_sat0));
        chk("stall last stable", int'(last0), int'(prev_last0));
      end
      if (v0 && ready0) begin
        hs0++;
        chk("dut0 beat was expected", int'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("dut0 data", int'(data0), e.data);
          chk("dut0 idx", int'(idx0), e.idx);
          chk("dut0 sat", int'(sat0), e.sat);
          chk("dut0 last", int'(last0), e.last);
        end
      end
      stall0     = v0 && !ready0;
      prev_data0 = data0;
      prev_idx0  = idx0;
      prev_sat0  = sat0;
      prev_last0 = last0;
      if (clr0 || done0) begin
        chk("dut0 done with clear_req", int'(done0), int'(clr0));
        if (clr0) clr_cnt0++;
      end
    end
  end

  // Monitor for the SHIFT=4 instance.
  always @(negedge clk) begin : mon4
    beat_t e;
    if (!rst) begin
      if (v4 && ready4) begin
        hs4++;
        chk("dut4 beat was expected", int'(q4.size() > 0), 1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          chk("dut4 data", int'(data4), e.data);
          chk("dut4 idx", int'(idx4), e.idx);
          chk("dut4 sat", int'(sat4), e.sat);
          chk("dut4 last", int'(last4), e.last);
        end
      end
      if (clr4 || done4) begin
        chk("dut4 done with clear_req", int'(done4), int'(clr4));
        if (clr4) clr_cnt4++;
      end
    end
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start4 = 1'b0; ready0 = 1'b1; ready4 = 1'b1;
    set_acc0(0, 0, 0, 0);
    set_acc4(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", int'(busy0), 0);
    chk("reset valid", int'(v0), 0);
    chk("reset data", int'(data0), 0);
    chk("reset clear_req", int'(clr0), 0);
    chk("reset dut4 busy", int'(busy4), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic drain with exact latency of the clear pulse.
    set_acc0(10, -20, 30, -40);
    push0(10, 0, 0, 0); push0(-20, 1, 0, 0); push0(30, 2, 0, 0); push0(-40, 3, 0, 1);
    hs_b = hs0; clr_b = clr_cnt0;
    pulse_start0();
    chk("t1 busy after start", int'(busy0), 1);
    repeat (4) tick();
    @(negedge clk);
    chk("t1 clear_req after N+4", int'(clr0), 1);
    chk("t1 done after N+4", int'(done0), 1);
    chk("t1 handshakes", hs0 - hs_b, 4);
    tick();
    @(negedge clk);
    chk("t1 clear_req gone after N+5", int'(clr0), 0);
    chk("t1 idle after N+5", int'(busy0), 0);
    chk("t1 clear pulses", clr_cnt0 - clr_b, 1);

    // Earliest restart at N+6, then three stall cycles ahead of every beat.
    push0(10, 0, 0, 0); push0(-20, 1, 0, 0); push0(30, 2, 0, 0); push0(-40, 3, 0, 1);
    hs_b = hs0; clr_b = clr_cnt0;
    ready0 = 1'b0;
    pulse_start0();
    chk("t2 restart accepted at N+6", int'(busy0), 1);
    for (int b = 0; b < 4; b++) begin
      repeat (3) tick();
      ready0 = 1'b1;
      tick();
      ready0 = 1'b0;
    end
    ready0 = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("t2 handshakes", hs0 - hs_b, 4);
    chk("t2 clear pulses", clr_cnt0 - clr_b, 1);
    chk("t2 idle", int'(busy0), 0);

    // Saturation at both extremes and exact in-range extremes.
    set_acc0(70000, -70000, 32767, -32768);
    push0(32767, 0, 1, 0); push0(-32768, 1, 1, 0); push0(32767, 2, 0, 0); push0(-32768, 3, 0, 1);
    hs_b = hs0; clr_b = clr_cnt0;
    pulse_start0();
    repeat (8) tick();
    @(negedge clk);
    chk("t3 handshakes", hs0 - hs_b, 4);
    chk("t3 clear pulses", clr_cnt0 - clr_b, 1);

    // Arithmetic shift by 4 rounds toward minus infinity.
    set_acc4(-17, 256, 15, -16);
    push4(-2, 0, 0, 0); push4(16, 1, 0, 0); push4(0, 2, 0, 0); push4(-1, 3, 0, 1);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("t4 handshakes", hs4, 4);
    chk("t4 clear pulses", clr_cnt4, 1);

    // Reset after the second beat abandons the drain without a clear.
    set_acc0(1, 2, 3, 4);
    push0(1, 0, 0, 0); push0(2, 1, 0, 0);
    clr_b = clr_cnt0;
    pulse_start0();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5 reset valid", int'(v0), 0);
    chk("t5 reset busy", int'(busy0), 0);
    chk("t5 reset data", int'(data0), 0);
    chk("t5 reset idx", int'(idx0), 0);
    chk("t5 reset last", int'(last0), 0);
    chk("t5 reset clear_req", int'(clr0), 0);
    chk("t5 reset done", int'(done0), 0);
    chk("t5 two beats before reset", int'(q0.size()), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5 idle after release", int'(busy0), 0);
    chk("t5 no clear after reset", clr_cnt0 - clr_b, 0);
    set_acc0(5, 6, 7, 8);
    push0(5, 0, 0, 0); push0(6, 1, 0, 0); push0(7, 2, 0, 0); push0(8, 3, 0, 1);
    hs_b = hs0; clr_b = clr_cnt0;
    pulse_start0();
    repeat (8) tick();
    @(negedge clk);
    chk("t5 handshakes after reset", hs0 - hs_b, 4);
    chk("t5 clear pulses after reset", clr_cnt0 - clr_b, 1);

    // Start held through SEND and FIN while acc_in changes after capture.
    set_acc0(100, -200, 300, -400);
    push0(100, 0, 0, 0); push0(-200, 1, 0, 0); push0(300, 2, 0, 0); push0(-400, 3, 0, 1);
    hs_b = hs0; clr_b = clr_cnt0;
    start0 = 1'b1;
    tick();
    set_acc0(1, 1, 1, 1);
    repeat (5) tick();
    start0 = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("t6 handshakes", hs0 - hs_b, 4);
    chk("t6 clear pulses", clr_cnt0 - clr_b, 1);
    chk("t6 idle", int'(busy0), 0);

    chk("dut0 scoreboard drained", int'(q0.size()), 0);
    chk("dut4 scoreboard drained", int'(q4.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
